colour_sequencer: RTL and testbench

//   Sequencer for the 3-bit-to-24-bit RGB colour converter. Steps conv_colour through
//   all 8 colour codes, pulsing conv_enable once per step so the converter captures

---
 rtl/colour_sequencer_pkg.sv | 44 ++++
 rtl/colour_sequencer_if.sv | 27 ++
 rtl/colour_sequencer_dwell_counter.sv | 29 ++
 rtl/colour_sequencer.sv | 89 ++++++++
 tb/tb_colour_sequencer.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/colour_sequencer_pkg.sv
// Shared types, constants and colour-order helper for the colour sequencer.
// Build option COLOUR_SEQ_GRAY_EN selects Gray visiting order instead of binary.
package colour_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  localparam int COLOUR_W    = 3;
  localparam int NUM_COLOURS = 8;

  typedef logic [COLOUR_W-1:0] colour_t;

  localparam colour_t FIRST_CODE = 3'd0;
`ifdef COLOUR_SEQ_GRAY_EN
  localparam colour_t LAST_CODE  = 3'd4;
`else
  localparam colour_t LAST_CODE  = 3'd7;
`endif

  // Successor of a code in the visiting order; the last code wraps to the first.
  function automatic colour_t next_code(input colour_t code);
`ifdef COLOUR_SEQ_GRAY_EN
    colour_t nxt;
    case (code)
      3'd0:    nxt = 3'd1;
      3'd1:    nxt = 3'd3;
      3'd3:    nxt = 3'd2;
      3'd2:    nxt = 3'd6;
      3'd6:    nxt = 3'd7;
      3'd7:    nxt = 3'd5;
      3'd5:    nxt = 3'd4;
      default: nxt = 3'd0;
    endcase
    return nxt;
`else
    return code + colour_t'(1);
`endif
  endfunction

endpackage

// File: rtl/colour_sequencer_if.sv
// Control/converter-side bundle of the colour sequencer.
// master = control logic driving the sequencer, slave = the sequencer itself.
interface colour_sequencer_if #(
  parameter int DWELL_W = 8
);
  import colour_seq_pkg::*;

  logic               start;
  logic               stop;
  logic               mode_loop;
  logic [DWELL_W-1:0] dwell;
  logic               conv_enable;
  colour_t            conv_colour;
  logic               busy;
  logic               done;

  modport master (
    output start, stop, mode_loop, dwell,
    input  conv_enable, conv_colour, busy, done
  );

  modport slave (
    input  start, stop, mode_loop, dwell,
    output conv_enable, conv_colour, busy, done
  );

endinterface

// File: rtl/colour_sequencer_dwell_counter.sv
// Dwell counter: counts hold cycles and flags the last one, treating dwell 0 as 1.
module dwell_counter #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               en,
  input  logic [DWELL_W-1:0] dwell,
  output logic               tc
);

  logic [DWELL_W-1:0] count_q;
  logic [DWELL_W-1:0] target;

  assign target = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
  assign tc     = en && (count_q == target);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + DWELL_W'(1);
    end
  end

endmodule

// File: rtl/colour_sequencer.sv
// Steps the RGB converter through all colour codes with a programmable dwell per code.
// Define COLOUR_SEQ_GRAY_EN (see colour_seq_pkg) for Gray visiting order.
module colour_sequencer
  import colour_seq_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  colour_sequencer_if.slave bus
);

  seq_state_e         state_q, state_d;
  colour_t            colour_q, colour_d;
  logic               loop_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               enable_q, busy_q, done_q;
  logic               tc;

  dwell_counter #(
    .DWELL_W (DWELL_W)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_q == LOAD),
    .en    (state_q == HOLD),
    .dwell (dwell_q),
    .tc    (tc)
  );

  always_comb begin
    state_d  = state_q;
    colour_d = colour_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d  = LOAD;
          colour_d = FIRST_CODE;
        end
      end
      LOAD: begin
        state_d = bus.stop ? IDLE : HOLD;
      end
      HOLD: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (tc) begin
          if ((colour_q == LAST_CODE) && !loop_q) begin
            state_d = DONE;
          end else begin
            state_d  = LOAD;
            colour_d = next_code(colour_q);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      colour_q <= FIRST_CODE;
      loop_q   <= 1'b0;
      dwell_q  <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      colour_q <= colour_d;
      enable_q <= (state_d == LOAD);
      busy_q   <= (state_d == LOAD) || (state_d == HOLD);
      done_q   <= (state_d == DONE);
      if ((state_q == IDLE) && (state_d == LOAD)) begin
        loop_q  <= bus.mode_loop;
        dwell_q <= bus.dwell;
      end
    end
  end

  assign bus.conv_enable = enable_q;
  assign bus.conv_colour = colour_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_colour_sequencer.sv
// Directed self-checking bench for colour_sequencer; expected colour order follows
// COLOUR_SEQ_GRAY_EN the same way the design does.
module tb_colour_sequencer;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  logic [2:0] seq [8];

  colour_sequencer_if #(.DWELL_W(8)) sif ();

  colour_sequencer #(
    .DWELL_W (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {conv_enable, conv_colour, busy, done}
  function automatic logic [5:0] outs();
    return {sif.conv_enable, sif.conv_colour, sif.busy, sif.done};
  endfunction

  task automatic check_val(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b (en,colour,busy,done)", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Enters LOAD; afterwards scrambles dwell/mode_loop to show they were latched.
  task automatic start_seq(input logic [7:0] dw, input logic loop);
    sif.dwell     = dw;
    sif.mode_loop = loop;
    sif.start     = 1'b1;
    tick();
    sif.start     = 1'b0;
    sif.dwell     = 8'd5;
    sif.mode_loop = ~loop;
  endtask

  // Called at the first LOAD cycle; checks ncyc consecutive cycles against the timing model.
  task automatic expect_seq(input string tag, input int dw, input int ncyc, input bit loop, input bit poke);
    int p;
    int k;
    logic [5:0] exp;
    p = 1 + ((dw == 0) ? 1 : dw);
    for (int c = 0; c < ncyc; c++) begin
      k = c / p;
      if (!loop && k >= 8) exp = {1'b0, seq[7], 1'b0, 1'b1};
      else                 exp = {((c % p) == 0), seq[k % 8], 1'b1, 1'b0};
      check_val($sformatf("%s c%0d", tag, c), outs(), exp);
      sif.start = poke && ((c == 3) || (c == 10));
      tick();
    end
    sif.start = 1'b0;
  endtask

  initial begin
`ifdef COLOUR_SEQ_GRAY_EN
    seq[0] = 3'd0; seq[1] = 3'd1; seq[2] = 3'd3; seq[3] = 3'd2;
    seq[4] = 3'd6; seq[5] = 3'd7; seq[6] = 3'd5; seq[7] = 3'd4;
`else
    for (int i = 0; i < 8; i++) seq[i] = 3'(i);
`endif
    rst_n         = 1'b0;
    sif.start     = 1'b0;
    sif.stop      = 1'b0;
    sif.mode_loop = 1'b0;
    sif.dwell     = 8'd0;

    #3;
    check_val("reset_outs", outs(), 6'b000000);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_val("idle_after_reset", outs(), 6'b000000);
    tick();
    tick();
    check_val("idle_no_start", outs(), 6'b000000);

    // Single pass, dwell 2, with start pokes while busy
    start_seq(8'd2, 1'b0);
    expect_seq("pass_d2", 2, 25, 1'b0, 1'b1);
    check_val("pass_d2_idle", outs(), {1'b0, seq[7], 2'b00});

    // dwell 0 behaves as dwell 1
    start_seq(8'd0, 1'b0);
    expect_seq("pass_d0", 0, 17, 1'b0, 1'b0);
    check_val("pass_d0_idle", outs(), {1'b0, seq[7], 2'b00});

    // Loop mode wraps, then stop during HOLD of the fourth colour of the second round
    start_seq(8'd1, 1'b1);
    expect_seq("loop_d1", 1, 23, 1'b1, 1'b0);
    check_val("loop_hold", outs(), {1'b0, seq[3], 2'b10});
    sif.stop = 1'b1;
    tick();
    sif.stop = 1'b0;
    check_val("stop_idle", outs(), {1'b0, seq[3], 2'b00});
    tick();
    check_val("stop_no_done", outs(), {1'b0, seq[3], 2'b00});

    // start and stop together in IDLE
    sif.start = 1'b1;
    sif.stop  = 1'b1;
    tick();
    check_val("start_stop_idle", outs(), {1'b0, seq[3], 2'b00});
    sif.start = 1'b0;
    sif.stop  = 1'b0;
    tick();
    check_val("start_stop_idle2", outs(), {1'b0, seq[3], 2'b00});

    // Async reset in the middle of a HOLD
    start_seq(8'd2, 1'b1);
    tick();
    tick();
    tick();
    tick();
    check_val("pre_reset_hold", outs(), {1'b0, seq[1], 2'b10});
    rst_n = 1'b0;
    #2;
    check_val("async_reset", outs(), 6'b000000);
    rst_n = 1'b1;
    tick();
    check_val("post_reset_idle", outs(), 6'b000000);

    // Fresh single pass after reset, dwell 1
    start_seq(8'd1, 1'b0);
    expect_seq("pass_d1", 1, 17, 1'b0, 1'b0);
    check_val("pass_d1_idle", outs(), {1'b0, seq[7], 2'b00});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
